fifo_srl_prog: RTL and testbench

//  - FWFT FIFO on shift-register LUT storage, parametrised successor of the plain SRL stream FIFO.
//  - Adds arbitrary DEPTH >= 2, an occupancy count, almost-full/almost-empty flags,
//    an optional registered head-of-queue output and sticky misuse flags.
//  - Sits between task ports on inter-task streams; drop-in for existing if_* handshake users.

---
 rtl/fifo_srl_prog_pkg.sv | 14 +
 rtl/fifo_srl_mem.sv | 37 +++
 rtl/fifo_srl_prog.sv | 145 ++++++++++++++
 tb/tb_fifo_srl_prog.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_srl_prog_pkg.sv
// Shared sizing helpers for the programmable SRL FIFO.
package fifo_srl_prog_pkg;

   // Width needed to hold an occupancy of 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Address width for a shift register of the given length, never below 1 bit.
   function automatic int addr_w(input int entries);
      return (entries <= 1) ? 1 : $clog2(entries);
   endfunction

endpackage

// File: rtl/fifo_srl_mem.sv
// Shift-register storage: new word enters at index 0, oldest word sits deepest.
// No reset; contents are only meaningful below the owner's occupancy count.
module fifo_srl_mem
   import fifo_srl_prog_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             ce,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] dout
);

   (* shreg_extract = "yes" *) logic [WIDTH-1:0] sr_q [DEPTH];

   // Shift one position per enabled cycle.
   always_ff @(posedge clk) begin
      if (ce) begin
         sr_q[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   // Asynchronous tap read; out-of-range addresses return zero.
   always_comb begin
      dout = '0;
      if (int'(addr) < DEPTH) begin
         dout = sr_q[addr];
      end
   end

endmodule

// File: rtl/fifo_srl_prog.sv
// First-word-fall-through FIFO on SRL storage with occupancy count,
// almost-full/almost-empty flags, optional head register and sticky misuse flags.
module fifo_srl_prog
   import fifo_srl_prog_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 32,
   parameter  int AF_MARGIN  = 2,
   parameter  int AE_MARGIN  = 2,
   parameter  int OUT_REG    = 0,
   localparam int CNT_WIDTH  = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [CNT_WIDTH-1:0]  if_count,
   output logic                  if_almost_full,
   output logic                  if_almost_empty,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam int SRL_DEPTH = (OUT_REG != 0) ? DEPTH - 1 : DEPTH;
   localparam int AW        = addr_w(SRL_DEPTH);
   localparam logic AF_RST  = (AF_MARGIN >= DEPTH);

   if (DATA_WIDTH < 1) begin : g_chk_width
      $error("fifo_srl_prog: DATA_WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_chk_depth
      $error("fifo_srl_prog: DEPTH must be >= 2");
   end
   if (AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_chk_af
      $error("fifo_srl_prog: AF_MARGIN out of range 0..DEPTH");
   end
   if (AE_MARGIN < 0 || AE_MARGIN > DEPTH) begin : g_chk_ae
      $error("fifo_srl_prog: AE_MARGIN out of range 0..DEPTH");
   end

   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;
   logic                  af_q, af_d;
   logic                  ae_q, ae_d;
   logic                  ov_q, ov_d;
   logic                  un_q, un_d;
   logic                  wr_acc, rd_acc;
   logic                  srl_ce;
   logic [AW-1:0]         srl_addr;
   logic [DATA_WIDTH-1:0] srl_dout;

   assign wr_acc = if_write & if_write_ce & full_n_q;
   assign rd_acc = if_read  & if_read_ce  & empty_n_q;

   // Next occupancy and every flag derived from it, plus sticky misuse capture.
   always_comb begin
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - 1'b1;
      end
      empty_n_d = (count_d != '0);
      full_n_d  = (count_d != CNT_WIDTH'(DEPTH));
      af_d      = (int'(count_d) >= (DEPTH - AF_MARGIN));
      ae_d      = (int'(count_d) <= AE_MARGIN);
      ov_d      = ov_q | (if_write & if_write_ce & ~full_n_q);
      un_d      = un_q | (if_read  & if_read_ce  & ~empty_n_q);
   end

   // Count and flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
         af_q      <= AF_RST;
         ae_q      <= 1'b1;
         ov_q      <= 1'b0;
         un_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         empty_n_q <= empty_n_d;
         full_n_q  <= full_n_d;
         af_q      <= af_d;
         ae_q      <= ae_d;
         ov_q      <= ov_d;
         un_q      <= un_d;
      end
   end

   if (OUT_REG != 0) begin : g_head
      logic [DATA_WIDTH-1:0] head_q;

      // The SRL holds everything behind the head word, so it only shifts when the
      // incoming word is not going straight into the head register.
      assign srl_ce   = wr_acc & (count_q != '0) & ~((count_q == CNT_WIDTH'(1)) & rd_acc);
      assign srl_addr = AW'(count_q - CNT_WIDTH'(2));

      // Head register: direct load when the FIFO drains to the new word, else refill from SRL tail.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            head_q <= '0;
         end else if (wr_acc && ((count_q == '0) || ((count_q == CNT_WIDTH'(1)) && rd_acc))) begin
            head_q <= if_din;
         end else if (rd_acc && (count_q >= CNT_WIDTH'(2))) begin
            head_q <= srl_dout;
         end
      end

      assign if_dout = head_q;
   end else begin : g_comb
      assign srl_ce   = wr_acc;
      assign srl_addr = AW'(count_q - CNT_WIDTH'(1));
      assign if_dout  = srl_dout;
   end

   fifo_srl_mem #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (SRL_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk  (clk),
      .ce   (srl_ce),
      .din  (if_din),
      .addr (srl_addr),
      .dout (srl_dout)
   );

   assign if_full_n       = full_n_q;
   assign if_empty_n      = empty_n_q;
   assign if_count        = count_q;
   assign if_almost_full  = af_q;
   assign if_almost_empty = ae_q;
   assign err_overflow    = ov_q;
   assign err_underflow   = un_q;

endmodule

// File: tb/tb_fifo_srl_prog.sv
// Bench for fifo_srl_prog: three configurations share one stimulus stream and
// are compared every cycle against a circular-buffer reference model.
module tb_fifo_srl_prog;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       wr, wce, rd, rce;
   logic [7:0] din;

   logic       full_n [NI];
   logic       empty_n[NI];
   logic       af     [NI];
   logic       ae     [NI];
   logic       ov     [NI];
   logic       un     [NI];
   logic [7:0] dout   [NI];
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;
   logic [2:0] cnt_c;
   logic [3:0] cntx   [NI];

   assign cntx[0] = {1'b0, cnt_a};
   assign cntx[1] = {2'b0, cnt_b};
   assign cntx[2] = {1'b0, cnt_c};

   int errors = 0;
   int checks = 0;

   // Instance 0: DEPTH=5 combinational head. 1: DEPTH=2 registered head. 2: DEPTH=7 registered head.
   fifo_srl_prog #(.DATA_WIDTH(8), .DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .OUT_REG(0)) u_a (
      .clk(clk), .reset_n(reset_n), .if_full_n(full_n[0]), .if_write_ce(wce), .if_write(wr),
      .if_din(din), .if_empty_n(empty_n[0]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[0]),
      .if_count(cnt_a), .if_almost_full(af[0]), .if_almost_empty(ae[0]),
      .err_overflow(ov[0]), .err_underflow(un[0]));

   fifo_srl_prog #(.DATA_WIDTH(8), .DEPTH(2), .AF_MARGIN(2), .AE_MARGIN(0), .OUT_REG(1)) u_b (
      .clk(clk), .reset_n(reset_n), .if_full_n(full_n[1]), .if_write_ce(wce), .if_write(wr),
      .if_din(din), .if_empty_n(empty_n[1]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[1]),
      .if_count(cnt_b), .if_almost_full(af[1]), .if_almost_empty(ae[1]),
      .err_overflow(ov[1]), .err_underflow(un[1]));

   fifo_srl_prog #(.DATA_WIDTH(8), .DEPTH(7), .AF_MARGIN(3), .AE_MARGIN(1), .OUT_REG(1)) u_c (
      .clk(clk), .reset_n(reset_n), .if_full_n(full_n[2]), .if_write_ce(wce), .if_write(wr),
      .if_din(din), .if_empty_n(empty_n[2]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[2]),
      .if_count(cnt_c), .if_almost_full(af[2]), .if_almost_empty(ae[2]),
      .err_overflow(ov[2]), .err_underflow(un[2]));

   function automatic int dep(input int id);
      case (id) 0: return 5; 1: return 2; default: return 7; endcase
   endfunction
   function automatic int afm(input int id);
      case (id) 0: return 2; 1: return 2; default: return 3; endcase
   endfunction
   function automatic int aem(input int id);
      case (id) 0: return 2; 1: return 0; default: return 1; endcase
   endfunction
   function automatic bit oreg(input int id);
      return (id != 0);
   endfunction

   // Reference model: circular buffer with occupancy, last head value and sticky errors.
   logic [7:0] mbuf[NI][16];
   int         mrd [NI];
   int         mcnt[NI];
   logic [7:0] mhd [NI];
   bit         mov [NI];
   bit         mun [NI];

   task automatic model_reset();
      for (int id = 0; id < NI; id++) begin
         mrd[id] = 0; mcnt[id] = 0; mhd[id] = 8'h00; mov[id] = 0; mun[id] = 0;
      end
   endtask

   task automatic model_step();
      bit wa, ra;
      for (int id = 0; id < NI; id++) begin
         wa = wr && wce && (mcnt[id] != dep(id));
         ra = rd && rce && (mcnt[id] != 0);
         if (wr && wce && !wa) mov[id] = 1;
         if (rd && rce && !ra) mun[id] = 1;
         if (ra) begin
            mrd[id]  = (mrd[id] + 1) % 16;
            mcnt[id] = mcnt[id] - 1;
         end
         if (wa) begin
            mbuf[id][(mrd[id] + mcnt[id]) % 16] = din;
            mcnt[id] = mcnt[id] + 1;
         end
         if (mcnt[id] > 0) mhd[id] = mbuf[id][mrd[id]];
      end
   endtask

   task automatic chk(input string nm, input int id, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[inst %0d] at %0t: got 0x%0h expected 0x%0h", nm, id, $time, act, exp);
      end
   endtask

   task automatic check_all();
      for (int id = 0; id < NI; id++) begin
         chk("full_n",   id, int'(full_n[id]),  int'(mcnt[id] != dep(id)));
         chk("empty_n",  id, int'(empty_n[id]), int'(mcnt[id] != 0));
         chk("count",    id, int'(cntx[id]),    mcnt[id]);
         chk("a_full",   id, int'(af[id]),      int'(mcnt[id] >= dep(id) - afm(id)));
         chk("a_empty",  id, int'(ae[id]),      int'(mcnt[id] <= aem(id)));
         chk("overflow", id, int'(ov[id]),      int'(mov[id]));
         chk("underflw", id, int'(un[id]),      int'(mun[id]));
         if (oreg(id) || mcnt[id] > 0) chk("dout", id, int'(dout[id]), int'(mhd[id]));
      end
   endtask

   task automatic set_in(input logic w, input logic wc, input logic r, input logic rc, input logic [7:0] d);
      wr = w; wce = wc; rd = r; rce = rc; din = d;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic op(input logic w, input logic r, input logic [7:0] d);
      set_in(w, 1'b1, r, 1'b1, d);
      cycle();
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic apply_reset();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] d;
      int         cnt;
      int         fn;
      int         en;
      int         afl;
      int         dv;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // Fill/drain of the DEPTH=5 combinational-head instance.
      tbl[0] = '{1'b1, 1'b0, 8'd1, 1, 1, 1, 0, 1};
      tbl[1] = '{1'b1, 1'b0, 8'd2, 2, 1, 1, 0, 1};
      tbl[2] = '{1'b1, 1'b0, 8'd3, 3, 1, 1, 1, 1};
      tbl[3] = '{1'b1, 1'b0, 8'd4, 4, 1, 1, 1, 1};
      tbl[4] = '{1'b1, 1'b0, 8'd5, 5, 0, 1, 1, 1};
      tbl[5] = '{1'b0, 1'b1, 8'd0, 4, 1, 1, 1, 2};
      tbl[6] = '{1'b0, 1'b1, 8'd0, 3, 1, 1, 1, 3};
      tbl[7] = '{1'b0, 1'b1, 8'd0, 2, 1, 1, 0, 4};
      tbl[8] = '{1'b0, 1'b1, 8'd0, 1, 1, 1, 0, 5};
      tbl[9] = '{1'b0, 1'b1, 8'd0, 0, 1, 0, 0, -1};

      reset_n = 1'b1;
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      model_reset();
      apply_reset();

      for (int i = 0; i < 10; i++) begin
         op(tbl[i].w, tbl[i].r, tbl[i].d);
         chk("tbl_count", 0, int'(cnt_a),      tbl[i].cnt);
         chk("tbl_fulln", 0, int'(full_n[0]),  tbl[i].fn);
         chk("tbl_emptn", 0, int'(empty_n[0]), tbl[i].en);
         chk("tbl_afull", 0, int'(af[0]),      tbl[i].afl);
         if (tbl[i].dv >= 0) chk("tbl_dout", 0, int'(dout[0]), tbl[i].dv);
      end

      // Reset in the middle of a partially filled stream.
      op(1'b1, 1'b0, 8'h77);
      op(1'b1, 1'b0, 8'h78);
      apply_reset();
      chk("mid_rst_cnt", 0, int'(cnt_a), 0);
      chk("mid_rst_ae",  0, int'(ae[0]), 1);

      // Simultaneous write and read hold the count and keep order.
      op(1'b1, 1'b0, 8'hA0);
      op(1'b1, 1'b0, 8'hA1);
      for (int k = 0; k < 10; k++) begin
         op(1'b1, 1'b1, 8'hA2 + 8'(k));
         chk("simul_cnt",  0, int'(cnt_a),   2);
         chk("simul_dout", 0, int'(dout[0]), 8'hA1 + k);
      end
      op(1'b0, 1'b1, 8'h00);
      op(1'b0, 1'b1, 8'h00);
      op(1'b1, 1'b1, 8'h5A);
      chk("empty_wr_rd_cnt",  0, int'(cnt_a),   1);
      chk("empty_wr_rd_dout", 0, int'(dout[0]), 8'h5A);
      chk("empty_wr_rd_un",   0, int'(un[0]),   1);

      // Full FIFO: read accepted, write dropped and flagged.
      apply_reset();
      for (int k = 0; k < 5; k++) op(1'b1, 1'b0, 8'h31 + 8'(k));
      op(1'b1, 1'b1, 8'hEE);
      chk("fullblk_cnt",  0, int'(cnt_a),   4);
      chk("fullblk_ov",   0, int'(ov[0]),   1);
      chk("fullblk_dout", 0, int'(dout[0]), 8'h32);
      for (int k = 0; k < 4; k++) op(1'b0, 1'b1, 8'h00);
      chk("fullblk_drain", 0, int'(empty_n[0]), 0);

      // Registered head, DEPTH=2.
      apply_reset();
      op(1'b1, 1'b0, 8'h11);
      chk("oreg_first",  1, int'(dout[1]),    8'h11);
      chk("oreg_emptn",  1, int'(empty_n[1]), 1);
      op(1'b1, 1'b1, 8'h22);
      chk("oreg_bypass", 1, int'(dout[1]),    8'h22);
      op(1'b1, 1'b0, 8'h33);
      chk("oreg_full",   1, int'(full_n[1]),  0);
      op(1'b0, 1'b1, 8'h00);
      chk("oreg_pop",    1, int'(dout[1]),    8'h33);
      op(1'b1, 1'b0, 8'h44);

      // Clock-enable gating of misuse flags.
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
      cycle();
      cycle();
      chk("ce_no_ov",  1, int'(ov[1]),   0);
      chk("ce_cnt",    1, int'(cnt_b),   2);
      op(1'b0, 1'b1, 8'h00);
      op(1'b0, 1'b1, 8'h00);
      chk("drain_hold", 1, int'(dout[1]), 8'h44);
      op(1'b0, 1'b1, 8'h00);
      chk("ce_un",     1, int'(un[1]),   1);

      // Randomised traffic with occasional asynchronous resets.
      apply_reset();
      for (int n = 0; n < 3000; n++) begin
         int unsigned wp;
         wp = (n / 200) % 4;
         set_in(($urandom_range(0, 3) < wp + 1) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) < 4 - wp) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                8'($urandom));
         cycle();
         if ($urandom_range(0, 499) == 0) apply_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
